alu_flag_ctrl: RTL and testbench

Execute-stage controller for the 16-bit ALU in the pipelined RISC core. Per instruction it:
- gates the 6-bit ALU opcode;
- resolves conditional execution (ADC/ADZ/NDC/NDZ) against the architectural carry and zero flags, which it owns;
- interlocks on a zero flag still pending from a load in MEM;
- reports BEQ outcome, register-write enable and stall-cycle statistics.

---
 rtl/alu_flag_ctrl_if.sv | 38 +++
 rtl/alu_flag_ctrl.sv | 111 +++++++++++
 tb/tb_alu_flag_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_flag_ctrl_if.sv
// Execute-stage flag controller bus: instruction/flag inputs from the pipeline
// and gated ALU control, stall and architectural flag outputs back to it.
interface alu_flag_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             ex_valid;
   logic             ex_flush;
   logic [5:0]       ex_opcode;
   logic             ex_regwrite;
   logic             ex_isload;
   logic             alu_cflag;
   logic             alu_zflag;
   logic             mem_loadz_valid;
   logic             mem_loadz;
   logic [5:0]       alu_opcode;
   logic             regwrite_en;
   logic             cancel;
   logic             stall;
   logic             beq_taken;
   logic             cflag;
   logic             zflag;
   logic [CNT_W-1:0] stall_cnt;

   // Pipeline side drives the instruction and flag sources
   modport master (
      output ex_valid, ex_flush, ex_opcode, ex_regwrite, ex_isload,
             alu_cflag, alu_zflag, mem_loadz_valid, mem_loadz,
      input  alu_opcode, regwrite_en, cancel, stall, beq_taken,
             cflag, zflag, stall_cnt
   );

   modport slave (
      input  ex_valid, ex_flush, ex_opcode, ex_regwrite, ex_isload,
             alu_cflag, alu_zflag, mem_loadz_valid, mem_loadz,
      output alu_opcode, regwrite_en, cancel, stall, beq_taken,
             cflag, zflag, stall_cnt
   );
endinterface

// File: rtl/alu_flag_ctrl.sv
// Execute-stage controller: owns the C/Z flags, resolves conditional execution,
// interlocks Z readers behind an outstanding load and counts stall cycles.
module alu_flag_ctrl #(
   parameter int CNT_W = 16
) (
   input logic           clk,
   input logic           rst,
   alu_flag_ctrl_if.slave bus
);

   typedef enum logic {
      RUN   = 1'b0,
      ZWAIT = 1'b1
   } state_t;

   state_t           state;
   state_t           state_next;
   logic             c_flag;
   logic             c_next;
   logic             z_flag;
   logic             z_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;

   logic [1:0]       op_class;
   logic [1:0]       cond;
   logic             live;
   logic             uses_z;
   logic             stall;
   logic             cancel;
   logic             fire;
   logic             arith;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= RUN;
         c_flag <= 1'b0;
         z_flag <= 1'b0;
         cnt    <= '0;
      end else begin
         state  <= state_next;
         c_flag <= c_next;
         z_flag <= z_next;
         cnt    <= cnt_next;
      end
   end

   // Conditions use only the registered flags; a pending load Z blocks readers
   always_comb begin
      op_class   = bus.ex_opcode[5:4];
      cond       = bus.ex_opcode[1:0];
      live       = bus.ex_valid & ~bus.ex_flush & ~rst;
      uses_z     = bus.ex_opcode[2] | (cond == 2'b01) | bus.ex_isload;
      stall      = live & (state == ZWAIT) & uses_z;
      cancel     = live & ~stall &
                   (((cond == 2'b10) & ~c_flag) | ((cond == 2'b01) & ~z_flag));
      fire       = live & ~stall & ~cancel;
      arith      = (op_class == 2'b01) | (op_class == 2'b10);

      state_next = state;
      c_next     = c_flag;
      z_next     = z_flag;
      cnt_next   = cnt;

      // A load computes its address through the ALU but never writes Z itself
      if (fire & arith) begin
         if (bus.ex_opcode[3]) begin
            c_next = bus.alu_cflag;
         end
         if (bus.ex_opcode[2] & ~bus.ex_isload) begin
            z_next = bus.alu_zflag;
         end
      end

      case (state)
         RUN: begin
            if (fire & bus.ex_isload) begin
               state_next = ZWAIT;
            end
         end
         ZWAIT: begin
            if (bus.mem_loadz_valid) begin
               z_next     = bus.mem_loadz;
               state_next = RUN;
            end
         end
         default: state_next = RUN;
      endcase

      if (stall & ~(&cnt)) begin
         cnt_next = cnt + CNT_W'(1);
      end
   end

   always_comb begin
      bus.alu_opcode  = 6'b0;
      bus.regwrite_en = 1'b0;
      bus.beq_taken   = 1'b0;
      bus.stall       = stall;
      bus.cancel      = cancel;
      if (fire) begin
         bus.alu_opcode  = {bus.ex_opcode[5:2], 2'b00};
         bus.regwrite_en = bus.ex_regwrite & (op_class != 2'b11);
         bus.beq_taken   = (op_class == 2'b11) & bus.alu_zflag;
      end
      bus.cflag     = c_flag;
      bus.zflag     = z_flag;
      bus.stall_cnt = cnt;
   end

endmodule

// File: tb/tb_alu_flag_ctrl.sv
// Self-checking bench for alu_flag_ctrl: directed scenarios with literal pins,
// then randomized traffic compared every cycle against a behavioural model.
module tb_alu_flag_ctrl;

   localparam int CNT_W = 4;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef struct packed {
      logic [5:0] op;
      logic       rw;
      logic       cancel;
      logic       stall;
      logic       beq;
      logic       fire;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;
   bit   checkEn = 1'b0;
   bit   prevStall = 1'b0;

   bit             mC = 1'b0;
   bit             mZ = 1'b0;
   bit             mPend = 1'b0;
   bit [CNT_W-1:0] mCnt = '0;
   exp_t           cur;

   alu_flag_ctrl_if #(.CNT_W(CNT_W)) bus ();

   alu_flag_ctrl #(.CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // What an instruction must do given the architectural flags and load status
   function automatic exp_t modelOut(input bit r, input bit c, input bit z, input bit pend,
                                     input bit v, input bit f, input logic [5:0] op,
                                     input bit rw, input bit ld, input bit az);
      exp_t e;
      bit   present;
      bit   readsZ;
      bit   condOk;
      e = '0;
      present = v && !f && !r;
      readsZ  = op[2] || (op[1:0] == 2'd1) || ld;
      case (op[1:0])
         2'd2:    condOk = c;
         2'd1:    condOk = z;
         default: condOk = 1'b1;
      endcase
      e.stall  = present && pend && readsZ;
      e.cancel = present && !e.stall && !condOk;
      e.fire   = present && !e.stall && condOk;
      if (e.fire) begin
         e.op  = {op[5:2], 2'b00};
         e.rw  = rw && (op[5:4] != 2'd3);
         e.beq = (op[5:4] == 2'd3) && az;
      end
      return e;
   endfunction

   always_comb cur = modelOut(rst, mC, mZ, mPend, bus.ex_valid, bus.ex_flush, bus.ex_opcode,
                              bus.ex_regwrite, bus.ex_isload, bus.alu_zflag);

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mC    <= 1'b0;
         mZ    <= 1'b0;
         mPend <= 1'b0;
         mCnt  <= '0;
      end else begin
         if (cur.fire && (bus.ex_opcode[5:4] inside {2'd1, 2'd2}) && bus.ex_opcode[3])
            mC <= bus.alu_cflag;
         if (cur.fire && (bus.ex_opcode[5:4] inside {2'd1, 2'd2}) && bus.ex_opcode[2] && !bus.ex_isload)
            mZ <= bus.alu_zflag;
         if (mPend && bus.mem_loadz_valid) begin
            mZ    <= bus.mem_loadz;
            mPend <= 1'b0;
         end else if (cur.fire && bus.ex_isload) begin
            mPend <= 1'b1;
         end
         if (cur.stall && mCnt != CNT_MAX)
            mCnt <= mCnt + 1'b1;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("alu_opcode", 32'(bus.alu_opcode), 32'(cur.op));
         checkOutput("regwrite_en", 32'(bus.regwrite_en), 32'(cur.rw));
         checkOutput("cancel", 32'(bus.cancel), 32'(cur.cancel));
         checkOutput("stall", 32'(bus.stall), 32'(cur.stall));
         checkOutput("beq_taken", 32'(bus.beq_taken), 32'(cur.beq));
         checkOutput("cflag", 32'(bus.cflag), 32'(mC));
         checkOutput("zflag", 32'(bus.zflag), 32'(mZ));
         checkOutput("stall_cnt", 32'(bus.stall_cnt), 32'(mCnt));
         prevStall <= cur.stall;
      end
   end

   task automatic applyStimulus(input bit r, input bit v, input bit f, input logic [5:0] op,
                                input bit rw, input bit ld, input bit ac, input bit az,
                                input bit lzv, input bit lz);
      @(posedge clk);
      #1;
      rst                 = r;
      bus.ex_valid        = v;
      bus.ex_flush        = f;
      bus.ex_opcode       = op;
      bus.ex_regwrite     = rw;
      bus.ex_isload       = ld;
      bus.alu_cflag       = ac;
      bus.alu_zflag       = az;
      bus.mem_loadz_valid = lzv;
      bus.mem_loadz       = lz;
   endtask

   task automatic idle();
      applyStimulus(0, 0, 0, 6'b0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      bus.ex_valid = 0; bus.ex_flush = 0; bus.ex_opcode = '0; bus.ex_regwrite = 0;
      bus.ex_isload = 0; bus.alu_cflag = 0; bus.alu_zflag = 0;
      bus.mem_loadz_valid = 0; bus.mem_loadz = 0;
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      checkEn = 1'b1;
      idle();
      @(negedge clk);
      checkOutput("pin_reset_c", 32'(bus.cflag), 32'd0);
      checkOutput("pin_reset_cnt", 32'(bus.stall_cnt), 32'd0);

      // ADD writing C/Z, then ADC depending on the new carry
      applyStimulus(0, 1, 0, 6'b011100, 1, 0, 1, 0, 0, 0);
      applyStimulus(0, 1, 0, 6'b011110, 1, 0, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("pin_add_c", 32'(bus.cflag), 32'd1);
      checkOutput("pin_add_z", 32'(bus.zflag), 32'd0);
      checkOutput("pin_adc_rw", 32'(bus.regwrite_en), 32'd1);
      checkOutput("pin_adc_op", 32'(bus.alu_opcode), 32'b011100);

      // ADZ with Z clear is cancelled
      applyStimulus(0, 1, 0, 6'b011101, 1, 0, 1, 1, 0, 0);
      @(negedge clk);
      checkOutput("pin_adz_cancel", 32'(bus.cancel), 32'd1);
      checkOutput("pin_adz_op", 32'(bus.alu_opcode), 32'd0);

      // Load then ADZ: two stall cycles, fires once Z arrives
      applyStimulus(0, 1, 0, 6'b010000, 1, 1, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 6'b011101, 1, 0, 1, 1, 0, 0);
      @(negedge clk);
      checkOutput("pin_ld_stall1", 32'(bus.stall), 32'd1);
      applyStimulus(0, 1, 0, 6'b011101, 1, 0, 1, 1, 1, 1);
      @(negedge clk);
      checkOutput("pin_ld_stall2", 32'(bus.stall), 32'd1);
      applyStimulus(0, 1, 0, 6'b011101, 1, 0, 1, 1, 0, 0);
      @(negedge clk);
      checkOutput("pin_adz_fire", 32'(bus.alu_opcode), 32'b011100);
      checkOutput("pin_stall_cnt2", 32'(bus.stall_cnt), 32'd2);
      checkOutput("pin_z_from_load", 32'(bus.zflag), 32'd1);

      // NDC in ZWAIT fires; the late load Z changes only Z
      applyStimulus(0, 1, 0, 6'b010000, 1, 1, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 6'b101010, 1, 0, 1, 0, 0, 0);
      @(negedge clk);
      checkOutput("pin_ndc_nostall", 32'(bus.stall), 32'd0);
      checkOutput("pin_ndc_op", 32'(bus.alu_opcode), 32'b101000);
      applyStimulus(0, 0, 0, 6'b0, 0, 0, 0, 0, 1, 0);
      idle();
      @(negedge clk);
      checkOutput("pin_ndc_c", 32'(bus.cflag), 32'd1);
      checkOutput("pin_ndc_z", 32'(bus.zflag), 32'd0);

      // Compare: taken branch, no register write, Z untouched; flushed copy does nothing
      applyStimulus(0, 1, 0, 6'b110000, 1, 0, 0, 1, 0, 0);
      @(negedge clk);
      checkOutput("pin_beq", 32'(bus.beq_taken), 32'd1);
      checkOutput("pin_beq_rw", 32'(bus.regwrite_en), 32'd0);
      applyStimulus(0, 1, 1, 6'b110000, 1, 0, 0, 1, 0, 0);
      @(negedge clk);
      checkOutput("pin_beq_flush", 32'(bus.beq_taken), 32'd0);
      checkOutput("pin_cmp_z", 32'(bus.zflag), 32'd0);

      // Reset in the middle of ZWAIT
      applyStimulus(0, 1, 0, 6'b010000, 1, 1, 0, 0, 0, 0);
      applyStimulus(1, 1, 0, 6'b011101, 1, 0, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("pin_rst_stall", 32'(bus.stall), 32'd0);
      checkOutput("pin_rst_c", 32'(bus.cflag), 32'd0);
      checkOutput("pin_rst_cnt", 32'(bus.stall_cnt), 32'd0);
      applyStimulus(0, 1, 0, 6'b011101, 1, 0, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("pin_after_rst_stall", 32'(bus.stall), 32'd0);
      checkOutput("pin_after_rst_cancel", 32'(bus.cancel), 32'd1);

      // Long interlock drives the stall counter into saturation
      applyStimulus(0, 1, 0, 6'b010000, 1, 1, 0, 0, 0, 0);
      repeat (20) applyStimulus(0, 1, 0, 6'b011101, 1, 0, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("pin_cnt_sat", 32'(bus.stall_cnt), 32'(CNT_MAX));
      applyStimulus(0, 1, 0, 6'b011101, 1, 0, 0, 0, 1, 1);
      idle();
      @(negedge clk);
      checkOutput("pin_cnt_hold", 32'(bus.stall_cnt), 32'(CNT_MAX));

      // Randomized traffic; a stalled instruction is held until it leaves EX
      for (int i = 0; i < 3000; i++) begin
         bit         r;
         bit         v;
         bit         f;
         logic [5:0] op;
         bit         rw;
         bit         ld;
         r  = ($urandom_range(0, 199) == 0);
         v  = ($urandom_range(0, 7) != 0);
         f  = ($urandom_range(0, 9) == 0);
         op = 6'($urandom_range(0, 63));
         rw = 1'($urandom);
         ld = ($urandom_range(0, 5) == 0);
         if (prevStall && !rst) begin
            v  = bus.ex_valid;
            f  = bus.ex_flush;
            op = bus.ex_opcode;
            rw = bus.ex_regwrite;
            ld = bus.ex_isload;
         end
         applyStimulus(r, v, f, op, rw, ld, 1'($urandom), 1'($urandom),
                       ($urandom_range(0, 3) == 0), 1'($urandom));
      end
      idle();
      @(negedge clk);
      checkEn = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
